matrix_keypad_scanner: RTL and testbench
========================================

# matrix_keypad_scanner

Scans the 4x4 matrix keypad, debounces it, and produces the `key_pulse` vector consumed by `mode_controller` and other key-driven control blocks. It drives one row low at a time, samples the four active-low column lines, and assembles a 16-bit frame per full scan. A key set is accepted only after several consecutive identical frames. For every accepted press, the block emits a single-cycle one-hot pulse.

## Interface
- `SCAN_DIV`, default 50000: clock cycles each row is driven before its columns are sampled (1 ms at 50 MHz).
- `DEBOUNCE_FRAMES`, default 5: number of consecutive identical valid frames required to accept a key set. Legal range is 2..15.
- `clk`  in  1  system clock; the only clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `row`  out  4  keypad row drive, active-low. Exactly one bit is low at any time.
- `col`  in  4  keypad column sense, active-low (pulled up externally) and asynchronous to `clk`.
- `key_pulse`  out  16  one-cycle one-hot pulse for a newly accepted press. Bit index = row*4 + col, so bit 0 is row0/col0 ("key 1").
- `key_state`  out  16  debounced level of all keys; 1 = pressed.

## Operation
- **Column synchronizer:** `col` passes through a 2-flop synchronizer before any use. The result is `col_s`.
- **Dwell counter:** `div_cnt` counts 0..SCAN_DIV-1 and wraps.
- **Row index:** `row_idx` (0..3) advances when `div_cnt` == SCAN_DIV-1, wrapping 3 -> 0.
- **Row drive:** `row` = ~(4'b0001 << row_idx), registered.
- **Sampling:** on the cycle with `div_cnt` == SCAN_DIV-1, `raw[row_idx*4 + c]` <= ~`col_s[c]` for c = 0..3. Sampling at the end of the dwell lets the lines settle after the row switch.
- **Frame end:** the sample cycle with `row_idx` == 3 is the frame end, E. The frame F is `raw`, with row 3's bits taken from the current sample.
- **Frame validity:** F is valid when popcount(F) <= 2. Frames with 3 or more bits set are treated as possible ghosting and rejected.
- **Debounce, evaluated at E only:**
  - If F is valid and F == `last_frame`: `match_cnt` <= min(`match_cnt` + 1, DEBOUNCE_FRAMES).
  - Otherwise: `match_cnt` <= (F valid ? 1 : 0).
  - In both cases, `last_frame` <= F.
- **Commit, at E:** commit happens when F is valid, the next `match_cnt` is >= DEBOUNCE_FRAMES, and F != `key_state`. On commit:
  - `key_state` <= F.
  - new = F & ~`key_state` (old value).
  - If new != 0, `key_pulse` <= lowest set bit of new. Otherwise no pulse.
- **Releases** update `key_state` without any pulse.
- **Pulse width:** `key_pulse` is 0 on every cycle except the cycle after a commit that pressed a key. It is never multi-hot.
- **Two-key press:** a simultaneous two-key press commits both bits in `key_state` but pulses only the lower index. A later press of a further key pulses that key only.
- **Rejected frames:** an invalid frame leaves `key_state` unchanged and resets `match_cnt` to 0.

## Timing
- **Reset values:**
  - `row` = 4'b1110.
  - `key_state` = 0, `key_pulse` = 0.
  - `div_cnt`, `row_idx`, `match_cnt`, `raw`, `last_frame` and the synchronizer flops are all 0.
- **Reset mid-operation:** all state clears immediately and any in-flight pulse is dropped. A key held through reset is re-detected and pulses again after DEBOUNCE_FRAMES full frames.
- **Frame period:** 4*SCAN_DIV cycles. The first frame end after reset is cycle 4*SCAN_DIV-1 (counting from 0 at the first edge after reset deassertion).
- **Press latency:** from a clean press to the `key_pulse` cycle, at most 2 (sync) + (DEBOUNCE_FRAMES+1)*4*SCAN_DIV cycles, and at least 2 + (DEBOUNCE_FRAMES-1)*4*SCAN_DIV cycles.
- **Output registration:** `key_state` and `key_pulse` update on the same edge, at E. Both are visible in cycle E+1, and `key_pulse` drops in E+2.
- **Bounce tolerance:** any change in the sampled bits between frames restarts the debounce count. Bounce shorter than (DEBOUNCE_FRAMES-1) frames therefore never commits.
- **Saturation:** `match_cnt` saturates, so a held key produces no repeat pulse.

## Test plan
All scenarios use SCAN_DIV=4 and DEBOUNCE_FRAMES=3 (frame = 16 cycles).
- **Reset:** assert `rst_n`=0 mid-scan -> `row`=4'b1110, `key_state`=0, `key_pulse`=0. After release, `row` walks 1110, 1101, 1011, 0111, changing every 4 cycles.
- **Single press:** pull `col[2]` low whenever `row[1]`=0 and hold -> exactly one `key_pulse`=16'h0040 with `key_state`=16'h0040, at the 3rd identical frame end + 1. No further pulses while held.
- **Bounce:** toggle key 0 for 1 frame pressed, 1 released, repeated -> `key_pulse` stays 0 and `key_state` stays 0. Then hold key 0 steady -> `key_pulse`=16'h0001 once.
- **Two keys:** press keys 0 and 5 together -> `key_state`=16'h0021 and a single pulse 16'h0001. Then add key 10 -> the frame is invalid (3 bits), `key_state` stays 16'h0021 and there is no pulse.
- **Release:** hold key 15 until committed, then release -> `key_state` becomes 0 after 3 clean frames, with no pulse on release.
- **Reset while holding:** while key 6 is held and committed, pulse `rst_n` low for 2 cycles -> `key_state`=0 immediately. `key_pulse`=16'h0040 reappears once, 3 frames later.

Source files
------------

// File: rtl/matrix_keypad_scanner.sv
// 4x4 active-low matrix keypad scanner with frame-based debounce, ghost rejection
// and a one-hot press pulse for the lowest newly pressed key.
module matrix_keypad_scanner #(
   parameter int SCAN_DIV        = 50000,
   parameter int DEBOUNCE_FRAMES = 5
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [3:0]  row,
   input  logic [3:0]  col,
   output logic [15:0] key_pulse,
   output logic [15:0] key_state
);

   localparam int              DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
   localparam logic [3:0]      DEB_MAX  = 4'(DEBOUNCE_FRAMES);

   // Number of keys seen in a frame; more than two may be phantom keys.
   function automatic logic [4:0] popcount16(input logic [15:0] v);
      logic [4:0] sum;
      sum = 5'd0;
      for (int i = 0; i < 16; i++) begin
         sum = sum + {4'd0, v[i]};
      end
      return sum;
   endfunction

   // Isolates the lowest set bit so the pulse is always one-hot.
   function automatic logic [15:0] lowest_set(input logic [15:0] v);
      return v & (~v + 16'd1);
   endfunction

   logic [3:0]       col_meta_q, col_meta_d;
   logic [3:0]       col_s_q, col_s_d;
   logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
   logic [1:0]       row_idx_q, row_idx_d;
   logic [3:0]       row_q, row_d;
   logic [15:0]      raw_q, raw_d;
   logic [15:0]      last_frame_q, last_frame_d;
   logic [3:0]       match_cnt_q, match_cnt_d;
   logic [15:0]      key_state_q, key_state_d;
   logic [15:0]      key_pulse_q, key_pulse_d;

   logic             sample_s;
   logic             frame_end_s;
   logic [15:0]      frame_s;
   logic             frame_valid_s;
   logic             commit_s;

   // Scan timing, sampling, debounce and commit decisions.
   always_comb begin
      col_meta_d = col;
      col_s_d    = col_meta_q;

      sample_s    = (div_cnt_q == DIV_LAST);
      frame_end_s = sample_s && (row_idx_q == 2'd3);

      if (sample_s) begin
         div_cnt_d = {DIV_W{1'b0}};
         row_idx_d = row_idx_q + 2'd1;
      end else begin
         div_cnt_d = div_cnt_q + DIV_ONE;
         row_idx_d = row_idx_q;
      end
      row_d = ~(4'b0001 << row_idx_d);

      raw_d = raw_q;
      if (sample_s) begin
         case (row_idx_q)
            2'd0:    raw_d[3:0]   = ~col_s_q;
            2'd1:    raw_d[7:4]   = ~col_s_q;
            2'd2:    raw_d[11:8]  = ~col_s_q;
            2'd3:    raw_d[15:12] = ~col_s_q;
            default: raw_d        = raw_q;
         endcase
      end else begin
         raw_d = raw_q;
      end

      // Row 3 is still being sampled at frame end, so take it straight from the synchronizer.
      frame_s       = {~col_s_q, raw_q[11:0]};
      frame_valid_s = (popcount16(frame_s) <= 5'd2);

      match_cnt_d  = match_cnt_q;
      last_frame_d = last_frame_q;
      if (frame_end_s) begin
         if (frame_valid_s && (frame_s == last_frame_q)) begin
            match_cnt_d = (match_cnt_q < DEB_MAX) ? (match_cnt_q + 4'd1) : DEB_MAX;
         end else begin
            match_cnt_d = frame_valid_s ? 4'd1 : 4'd0;
         end
         last_frame_d = frame_s;
      end else begin
         match_cnt_d  = match_cnt_q;
         last_frame_d = last_frame_q;
      end

      commit_s = frame_end_s && frame_valid_s && (match_cnt_d >= DEB_MAX) &&
                 (frame_s != key_state_q);

      if (commit_s) begin
         key_state_d = frame_s;
         key_pulse_d = lowest_set(frame_s & ~key_state_q);
      end else begin
         key_state_d = key_state_q;
         key_pulse_d = 16'h0000;
      end
   end

   // State registers; everything clears asynchronously on reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_meta_q   <= 4'h0;
         col_s_q      <= 4'h0;
         div_cnt_q    <= {DIV_W{1'b0}};
         row_idx_q    <= 2'd0;
         row_q        <= 4'b1110;
         raw_q        <= 16'h0000;
         last_frame_q <= 16'h0000;
         match_cnt_q  <= 4'd0;
         key_state_q  <= 16'h0000;
         key_pulse_q  <= 16'h0000;
      end else begin
         col_meta_q   <= col_meta_d;
         col_s_q      <= col_s_d;
         div_cnt_q    <= div_cnt_d;
         row_idx_q    <= row_idx_d;
         row_q        <= row_d;
         raw_q        <= raw_d;
         last_frame_q <= last_frame_d;
         match_cnt_q  <= match_cnt_d;
         key_state_q  <= key_state_d;
         key_pulse_q  <= key_pulse_d;
      end
   end

   assign row       = row_q;
   assign key_state = key_state_q;
   assign key_pulse = key_pulse_q;

endmodule

// File: tb/tb_matrix_keypad_scanner.sv
// Directed bench for matrix_keypad_scanner with SCAN_DIV=4, DEBOUNCE_FRAMES=3 (16-cycle frames).
module tb_matrix_keypad_scanner;

   localparam int FRAME = 16;

   logic        clk;
   logic        rst_n;
   logic [3:0]  row;
   logic [3:0]  col;
   logic [15:0] key_pulse;
   logic [15:0] key_state;
   logic [15:0] keys;

   int          n_cmp;
   int          n_fail;
   int          pulse_cnt;
   logic [15:0] last_pulse;

   typedef struct {
      logic [15:0] keys;
      int          frames;
      logic [15:0] exp_state;
      int          exp_pulses;
      logic [15:0] exp_last;
   } vec_t;

   vec_t vecs[$];

   matrix_keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_FRAMES(3)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .row       (row),
      .col       (col),
      .key_pulse (key_pulse),
      .key_state (key_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Keypad model: a pressed key shorts its column to the currently driven row.
   always_comb begin
      col = 4'hF;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (!row[r] && keys[r*4+c]) col[c] = 1'b0;
         end
      end
   end

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Pulse monitor: counts pulses and checks each one is one-hot.
   always @(negedge clk) begin
      if (rst_n && key_pulse != 16'h0000) begin
         pulse_cnt++;
         last_pulse = key_pulse;
         n_cmp++;
         if (!$onehot(key_pulse)) begin
            n_fail++;
            $display("FAIL pulse_onehot: got %h expected one-hot", key_pulse);
         end
      end
   end

   initial begin
      n_cmp = 0; n_fail = 0; pulse_cnt = 0; last_pulse = 16'h0;
      keys  = 16'h0000;
      rst_n = 1'b0;

      // {keys, frames, expected key_state, expected pulses, expected last pulse}
      vecs.push_back('{16'h0000, 2, 16'h0000, 0, 16'h0000});
      vecs.push_back('{16'h0040, 2, 16'h0000, 0, 16'h0000});
      vecs.push_back('{16'h0040, 1, 16'h0040, 1, 16'h0040});
      vecs.push_back('{16'h0040, 4, 16'h0040, 0, 16'h0000});
      vecs.push_back('{16'h0000, 2, 16'h0040, 0, 16'h0000});
      vecs.push_back('{16'h0000, 1, 16'h0000, 0, 16'h0000});
      for (int b = 0; b < 3; b++) begin
         vecs.push_back('{16'h0001, 1, 16'h0000, 0, 16'h0000});
         vecs.push_back('{16'h0000, 1, 16'h0000, 0, 16'h0000});
      end
      vecs.push_back('{16'h0001, 3, 16'h0001, 1, 16'h0001});
      vecs.push_back('{16'h0000, 3, 16'h0000, 0, 16'h0000});
      vecs.push_back('{16'h0021, 3, 16'h0021, 1, 16'h0001});
      vecs.push_back('{16'h0421, 4, 16'h0021, 0, 16'h0000});
      vecs.push_back('{16'h0021, 3, 16'h0021, 0, 16'h0000});
      vecs.push_back('{16'h0020, 3, 16'h0020, 0, 16'h0000});
      vecs.push_back('{16'h0420, 3, 16'h0420, 1, 16'h0400});
      vecs.push_back('{16'h0000, 3, 16'h0000, 0, 16'h0000});
      vecs.push_back('{16'h0007, 4, 16'h0000, 0, 16'h0000});
      vecs.push_back('{16'h0000, 3, 16'h0000, 0, 16'h0000});
      vecs.push_back('{16'h8000, 3, 16'h8000, 1, 16'h8000});
      vecs.push_back('{16'h0000, 2, 16'h8000, 0, 16'h0000});
      vecs.push_back('{16'h0000, 1, 16'h0000, 0, 16'h0000});

      // Reset mid-scan, then check the row walk.
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (7) @(negedge clk);
      check("row_before_reset", {12'h0, row}, 16'h000D);
      rst_n = 1'b0;
      #1;
      check("reset_row", {12'h0, row}, 16'h000E);
      check("reset_state", key_state, 16'h0000);
      check("reset_pulse", key_pulse, 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         logic [3:0] exp_row;
         @(negedge clk);
         exp_row = ~(4'b0001 << ((k / 4) % 4));
         check($sformatf("row_walk_%0d", k), {12'h0, row}, {12'h0, exp_row});
      end

      // Table-driven frames; each window starts just after a frame end.
      foreach (vecs[i]) begin
         keys       = vecs[i].keys;
         pulse_cnt  = 0;
         last_pulse = 16'h0000;
         repeat (vecs[i].frames * FRAME) @(posedge clk);
         @(negedge clk);
         #1;
         check($sformatf("vec%0d_state", i), key_state, vecs[i].exp_state);
         check($sformatf("vec%0d_pulses", i), 16'(pulse_cnt), 16'(vecs[i].exp_pulses));
         if (vecs[i].exp_pulses > 0)
            check($sformatf("vec%0d_pulse_val", i), last_pulse, vecs[i].exp_last);
      end

      // Reset while a committed key is held; exact re-detect timing afterwards.
      keys = 16'h0040;
      repeat (3 * FRAME) @(posedge clk);
      @(negedge clk);
      check("hold6_state", key_state, 16'h0040);
      rst_n = 1'b0;
      #1;
      check("hold6_reset_state", key_state, 16'h0000);
      check("hold6_reset_row", {12'h0, row}, 16'h000E);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int k = 1; k <= 49; k++) begin
         @(negedge clk);
         check($sformatf("redetect_pulse_%0d", k), key_pulse, (k == 48) ? 16'h0040 : 16'h0000);
         check($sformatf("redetect_state_%0d", k), key_state, (k >= 48) ? 16'h0040 : 16'h0000);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
